// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the CPU requester, the host/loader requester and the shared
// byte-lane data memory signals of dmem_arbiter.
//   cpu_* / host_*  : req, word addr, wdata, active-low per-lane wren (in),
//                     gnt and rdata (out)
//   mem_*           : addr, wdata, active-low wren (out), rdata (in)
//   busy            : high when either requester owns the memory
// Modports: slave  = the arbiter side
//           master = the requesters + memory side (testbench / SoC glue)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wren;
  logic              cpu_gnt;
  logic [31:0]       cpu_rdata;

  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic [3:0]        host_wren;
  logic              host_gnt;
  logic [31:0]       host_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wren;
  logic [31:0]       mem_rdata;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_wren,
    input  host_req, host_addr, host_wdata, host_wren,
    input  mem_rdata,
    output cpu_gnt, cpu_rdata, host_gnt, host_rdata,
    output mem_addr, mem_wdata, mem_wren, busy
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_wren,
    output host_req, host_addr, host_wdata, host_wren,
    output mem_rdata,
    input  cpu_gnt, cpu_rdata, host_gnt, host_rdata,
    input  mem_addr, mem_wdata, mem_wren, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-requester (CPU, host/loader) arbiter in front of a shared data memory
// built from four byte-lane RAMs with active-low lane write enables.
// The owner's address/data/enables pass combinationally to the memory and the
// owner alone sees mem_rdata; the idle bus drives zeros and no write.
//
// Ports:
//   clk   : single clock, all state changes on posedge
//   rstd  : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (requester, grant, memory and busy signals)
// Parameters:
//   ADDR_W   : word address width
//   MAX_HOLD : owner cycles before a waiting requester may preempt (1..7)
// Build option:
//   ARB_ROUND_ROBIN_EN defined   -> round-robin ties and hold-limit preemption
//   ARB_ROUND_ROBIN_EN undefined -> fixed priority, CPU wins and preempts host
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input logic          clk,
  input logic          rstd,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } state_e;

  typedef enum logic {
    LAST_CPU  = 1'b0,
    LAST_HOST = 1'b1
  } owner_e;

  localparam logic [2:0] HOLD_SAT = 3'(MAX_HOLD);
`ifdef ARB_ROUND_ROBIN_EN
  // Preempting once the counter reaches MAX_HOLD-1 gives the owner exactly
  // MAX_HOLD cycles; ">=" also covers an owner whose counter already
  // saturated before the other side started requesting.
  localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);
`endif

  state_e r_state;
  state_e w_next;
  logic [2:0] r_hold;
  owner_e r_last_owner;

  logic w_cpu_own;
  logic w_host_own;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic [3:0] w_mem_wren;

  // -------------------------------------------------------------------------
  // Next-state selection
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every path starts from a default, so no latch can be inferred.
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.cpu_req && bus.host_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          w_next = (r_last_owner == LAST_CPU) ? OWN_HOST : OWN_CPU;
`else
          w_next = OWN_CPU;
`endif
        end else if (bus.cpu_req) begin
          w_next = OWN_CPU;
        end else if (bus.host_req) begin
          w_next = OWN_HOST;
        end
      end
      OWN_CPU: begin
        if (!bus.cpu_req) begin
          w_next = bus.host_req ? OWN_HOST : IDLE;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (bus.host_req && (r_hold >= HOLD_LAST)) begin
          w_next = OWN_HOST;
        end
`endif
      end
      OWN_HOST: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (!bus.host_req) begin
          w_next = bus.cpu_req ? OWN_CPU : IDLE;
        end else if (bus.cpu_req && (r_hold >= HOLD_LAST)) begin
          w_next = OWN_CPU;
        end
`else
        if (bus.cpu_req) begin
          w_next = OWN_CPU;
        end else if (!bus.host_req) begin
          w_next = IDLE;
        end
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, hold counter and last owner
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_last_owner <= LAST_HOST;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      r_state <= w_next;
      if (w_next != r_state) begin
        r_hold <= '0;
      end else if (r_hold != HOLD_SAT) begin
        r_hold <= r_hold + 3'd1;
      end
      r_last_owner <= (w_next == OWN_CPU)  ? LAST_CPU  :
                      (w_next == OWN_HOST) ? LAST_HOST : r_last_owner;
    end
  end

  // -------------------------------------------------------------------------
  // Grants decode registered state only; reset forces IDLE immediately, which
  // drops the grants and parks the memory bus in the same cycle.
  // -------------------------------------------------------------------------
  assign w_cpu_own  = (r_state == OWN_CPU);
  assign w_host_own = (r_state == OWN_HOST);

  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_wren  = 4'b1111;
    if (w_cpu_own) begin
      w_mem_addr  = bus.cpu_addr;
      w_mem_wdata = bus.cpu_wdata;
      w_mem_wren  = bus.cpu_wren;
    end else if (w_host_own) begin
      w_mem_addr  = bus.host_addr;
      w_mem_wdata = bus.host_wdata;
      w_mem_wren  = bus.host_wren;
    end
  end

  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.mem_wren   = w_mem_wren;
  assign bus.cpu_gnt    = w_cpu_own;
  assign bus.host_gnt   = w_host_own;
  assign bus.busy       = w_cpu_own | w_host_own;
  assign bus.cpu_rdata  = w_cpu_own  ? bus.mem_rdata : 32'd0;
  assign bus.host_rdata = w_host_own ? bus.mem_rdata : 32'd0;

endmodule
